// File: rtl/mem_req_unit.sv
// mem_req_unit: issues load/store requests on an SRAM-like bus and returns in-order responses.
// Alignment exceptions are enabled by defining MEM_REQ_ALE_EN; otherwise misaligned addresses are aligned down.
module mem_req_unit #(
    parameter int DATA_W      = 32,
    parameter int OUTST_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_is_ld,
    input  logic                req_is_st,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                req_ready,
    output logic                ale,
    input  logic                flush,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [1:0]          mem_size,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [31:0]         mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                resp_valid,
    output logic                resp_is_st,
    output logic [DATA_W-1:0]   resp_data
);
    localparam int NB = DATA_W / 8;
    localparam int OB = $clog2(NB);
    localparam int PW = $clog2(OUTST_DEPTH);
    localparam int CW = PW + 1;

    logic                   is_mem, full, push, pop;
    logic [31:0]            addr_eff;
    logic [OB-1:0]          off;
    logic [3:0]             nbytes;
    logic [15:0]            lanes;
    logic [PW-1:0]          wp, rp;
    logic [CW-1:0]          count;
    logic [OUTST_DEPTH-1:0] t_ld, t_sg, t_dis;
    logic [1:0]             t_sz  [OUTST_DEPTH];
    logic [OB-1:0]          t_off [OUTST_DEPTH];
    logic [63:0]            sh, ld_data;

    assign is_mem = req_is_ld | req_is_st;

`ifdef MEM_REQ_ALE_EN
    logic misaligned;
    assign misaligned = (req_size == 2'd1 & req_addr[0]) | (req_size == 2'd2 & |req_addr[1:0]) |
                        (req_size == 2'd3 & |req_addr[2:0]);
    assign ale      = ~reset & req_valid & is_mem & misaligned & ~flush;
    assign addr_eff = req_addr;
`else
    assign ale      = 1'b0;
    assign addr_eff = req_addr & ~((32'd1 << req_size) - 32'd1);
`endif

    // full uses the registered count, so a same-cycle pop never unblocks issue
    assign full      = count == CW'(OUTST_DEPTH);
    assign mem_req   = ~reset & req_valid & is_mem & ~ale & ~full & ~flush;
    assign req_ready = ~reset & ((req_valid & ~is_mem) | ale | (mem_req & mem_addr_ok));
    assign push      = mem_req & mem_addr_ok;
    assign pop       = mem_data_ok & (count != '0);

    assign mem_wr    = req_is_st;
    assign mem_size  = req_size;
    assign mem_addr  = addr_eff;
    assign off       = addr_eff[OB-1:0];
    assign nbytes    = 4'd1 << req_size;
    assign lanes     = (16'd1 << nbytes) - 16'd1;
    assign mem_wstrb = req_is_st ? NB'(lanes << off) : '0;

    always_comb begin
        mem_wdata = '0;
        for (int i = 0; i < NB; i++)
            mem_wdata[i*8 +: 8] = req_wdata[{3'(i) & (nbytes[2:0] - 3'd1) & 3'(NB - 1), 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wp    <= '0;
            rp    <= '0;
            t_dis <= '0;
        end else begin
            if (push) begin
                t_ld[wp]  <= req_is_ld;
                t_sz[wp]  <= req_size;
                t_sg[wp]  <= req_signed;
                t_off[wp] <= off;
                t_dis[wp] <= 1'b0;
                wp        <= wp + PW'(1);
            end
            if (flush)
                t_dis <= '1;
            if (pop)
                rp <= rp + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign resp_valid = ~reset & pop & ~t_dis[rp] & ~flush;
    assign resp_is_st = ~t_ld[rp];
    assign sh         = 64'(mem_rdata) >> {t_off[rp], 3'b000};
    assign ld_data    = t_sz[rp] == 2'd0 ? {{56{t_sg[rp] & sh[7]}}, sh[7:0]} :
                        t_sz[rp] == 2'd1 ? {{48{t_sg[rp] & sh[15]}}, sh[15:0]} :
                        t_sz[rp] == 2'd2 ? {{32{t_sg[rp] & sh[31]}}, sh[31:0]} : sh;
    assign resp_data  = t_ld[rp] ? DATA_W'(ld_data) : '0;
endmodule
